// File: rtl/sfp_port_ctrl.sv
`timescale 1ns/1ps
// SFP cage port controller: input sync/debounce, power-up sequencing, fault retry.
// Define SFP_FAULT_COUNT_EN to build the saturating RUN->FAULT entry counter.
module sfp_port_ctrl #(
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned SETTLE   = 1024,
  parameter int unsigned RETRY    = 4096
) (
  input  logic       clk100,
  input  logic       sys_rst,
  input  logic       enable,
  input  logic       sfp_clk_alarm_b,
  input  logic       tx_fault,
  input  logic       rx_los,
  output logic       tx_disable,
  output logic       port_rst,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] fault_cnt
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAIT_CLK = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [15:0] DB_LAST     = 16'(DEBOUNCE - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] RETRY_LAST  = 16'(RETRY - 1);

  // Bit 0 carries the alarm inverted so every synchroniser and qualified level resets inactive.
  logic [2:0]       raw;
  logic [2:0]       sync1, sync2;
  logic [2:0]       qual, qual_next;
  logic [2:0][15:0] db_cnt, cnt_next;
  logic             alarm_q, fault_q, los_q;
  state_t           state_q, state_next;
  logic [15:0]      timer;

  assign raw = {rx_los, tx_fault, ~sfp_clk_alarm_b};

  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      sync1  <= '0;
      sync2  <= '0;
      qual   <= '0;
      db_cnt <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      qual   <= qual_next;
      db_cnt <= cnt_next;
    end
  end

  always_comb begin
    qual_next = qual;
    cnt_next  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2[i] != qual[i]) begin
        if (db_cnt[i] == DB_LAST) qual_next[i] = sync2[i];
        else                      cnt_next[i]  = db_cnt[i] + 16'd1;
      end
    end
  end

  // The FSM looks at the qualified level being written this cycle, so a level
  // qualified on an edge acts on that same edge rather than one cycle later.
  assign alarm_q = qual_next[0];
  assign fault_q = qual_next[1];
  assign los_q   = qual_next[2];

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_OFF:      if (enable)                state_next = ST_WAIT_CLK;
      ST_WAIT_CLK: if (!alarm_q)              state_next = ST_SETTLE;
      ST_SETTLE:   if (timer == SETTLE_LAST)  state_next = ST_RUN;
      ST_RUN:      if (fault_q || alarm_q)    state_next = ST_FAULT;
      ST_FAULT:    if (timer == RETRY_LAST)   state_next = ST_WAIT_CLK;
      default:                                state_next = ST_OFF;
    endcase
    if (!enable) state_next = ST_OFF;
  end

  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_OFF;
      timer      <= '0;
      tx_disable <= 1'b1;
      port_rst   <= 1'b1;
      link_up    <= 1'b0;
    end else begin
      state_q    <= state_next;
      timer      <= (state_next != state_q) ? '0 : timer + 16'd1;
      tx_disable <= !(state_next == ST_SETTLE || state_next == ST_RUN);
      port_rst   <= (state_next != ST_RUN);
      link_up    <= (state_next == ST_RUN) && !los_q;
    end
  end

  assign state = state_q;

`ifdef SFP_FAULT_COUNT_EN
  logic [7:0] fault_cnt_q;

  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      fault_cnt_q <= '0;
    end else if (state_q == ST_RUN && state_next == ST_FAULT && fault_cnt_q != '1) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign fault_cnt = fault_cnt_q;
`else
  assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_sfp_port_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for sfp_port_ctrl: cycle-level reference model feeds a queue, monitor compares.
module tb_sfp_port_ctrl;

  localparam int DB = 4;
  localparam int SP = 8;
  localparam int RP = 16;
`ifdef SFP_FAULT_COUNT_EN
  localparam int FC_MAX = 255;
`else
  localparam int FC_MAX = 0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       enable, alarm_b, tx_fault, rx_los;
  logic       tx_disable, port_rst, link_up;
  logic [2:0] state;
  logic [7:0] fault_cnt;

  int checks = 0;
  int passed = 0;

  sfp_port_ctrl #(.DEBOUNCE(DB), .SETTLE(SP), .RETRY(RP)) dut (
    .clk100(clk), .sys_rst(sys_rst), .enable(enable),
    .sfp_clk_alarm_b(alarm_b), .tx_fault(tx_fault), .rx_los(rx_los),
    .tx_disable(tx_disable), .port_rst(port_rst), .link_up(link_up),
    .state(state), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       txd;
    logic       prst;
    logic       lnk;
    logic [7:0] fc;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t actual();
    return '{st: state, txd: tx_disable, prst: port_rst, lnk: link_up, fc: fault_cnt};
  endfunction

  function automatic void compare(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s @%0t: got st=%0d txd=%b prst=%b link=%b fcnt=%0d, required st=%0d txd=%b prst=%b link=%b fcnt=%0d",
                  name, $time, a.st, a.txd, a.prst, a.lnk, a.fc, e.st, e.txd, e.prst, e.lnk, e.fc);
  endfunction

  // Reference model: states as integers 0..4, time in absolute cycles.
  logic [2:0] dl[$];
  bit         mq[3];
  int         agree_at[3];
  int         mstate, entry, cyc, mfc;

  function automatic void model_reset();
    dl.delete();
    dl.push_back(3'b000);
    dl.push_back(3'b000);
    for (int i = 0; i < 3; i++) begin mq[i] = 0; agree_at[i] = 0; end
    mstate = 0; entry = 0; cyc = 0; mfc = 0;
  endfunction

  function automatic exp_t model_step();
    logic [2:0] used;
    int nxt;
    exp_t e;
    cyc++;
    used = dl.pop_front();
    dl.push_back({rx_los, tx_fault, ~alarm_b});
    for (int i = 0; i < 3; i++) begin
      if (used[i] == mq[i]) agree_at[i] = cyc;
      else if (cyc - agree_at[i] >= DB) begin mq[i] = used[i]; agree_at[i] = cyc; end
    end
    nxt = mstate;
    if (!enable) nxt = 0;
    else case (mstate)
      0: nxt = 1;
      1: if (!mq[0]) nxt = 2;
      2: if (cyc - entry == SP) nxt = 3;
      3: if (mq[0] || mq[1]) begin
           nxt = 4;
`ifdef SFP_FAULT_COUNT_EN
           if (mfc < 255) mfc++;
`endif
         end
      4: if (cyc - entry == RP) nxt = 1;
      default: nxt = 0;
    endcase
    if (nxt != mstate) entry = cyc;
    mstate = nxt;
    e.st   = 3'(mstate);
    e.txd  = (mstate != 2 && mstate != 3);
    e.prst = (mstate != 3);
    e.lnk  = (mstate == 3) && !mq[2];
    e.fc   = 8'(mfc);
    return e;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge sys_rst);
      if (sys_rst) begin
        model_reset();
        exp_q.delete();
      end else begin
        exp_q.push_back(model_step());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!sys_rst) begin
        if (exp_q.size() > 0) compare("scoreboard", actual(), exp_q.pop_front());
        else begin
          checks++;
          $display("FAIL scoreboard_empty @%0t: got no expectation, required one per cycle", $time);
        end
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int k = 0;
    while (state !== s && k < limit) begin @(negedge clk); k++; end
    checks++;
    if (state === s) passed++;
    else $display("FAIL %s: got state=%0d, required %0d within %0d cycles", name, state, s, limit);
  endtask

  task automatic check_state(input logic [2:0] s, input string name);
    checks++;
    if (state === s) passed++;
    else $display("FAIL %s: got state=%0d, required %0d", name, state, s);
  endtask

  task automatic check_bit(input logic a, input logic e, input string name);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %b, required %b", name, a, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int entries, k;
    logic [2:0] prev;

    sys_rst = 1'b1; enable = 1'b0; alarm_b = 1'b1; tx_fault = 1'b0; rx_los = 1'b0;
    repeat (3) @(negedge clk);
    compare("reset_values", actual(), '{st: 3'd0, txd: 1'b1, prst: 1'b1, lnk: 1'b0, fc: 8'd0});
    sys_rst = 1'b0;
    enable  = 1'b1;
    wait_state(3'd3, 40, "power_up_run");

    // Sub-threshold fault pulses must be filtered out.
    for (int n = 0; n < 4; n++) begin
      tx_fault = 1'b1;
      repeat ($urandom_range(1, DB - 1)) @(negedge clk);
      tx_fault = 1'b0;
      repeat (12) @(negedge clk);
    end
    check_state(3'd3, "short_fault_ignored");

    tx_fault = 1'b1;
    repeat (5) @(negedge clk);
    check_state(3'd3, "fault_before_latency");
    @(negedge clk);
    check_state(3'd4, "fault_latency_6");
    tx_fault = 1'b0;
    wait_state(3'd3, 80, "fault_recovery");

    rx_los = 1'b1;
    repeat (5) @(negedge clk);
    check_bit(link_up, 1'b1, "los_before_latency");
    @(negedge clk);
    check_bit(link_up, 1'b0, "los_latency_6");
    rx_los = 1'b0;
    repeat (6) @(negedge clk);
    check_bit(link_up, 1'b1, "los_clear_latency_6");
    for (int n = 0; n < 6; n++) begin
      rx_los = ~rx_los;
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    rx_los = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tx_fault = 1'b1;
      repeat ($urandom_range(DB, DB + 6)) @(negedge clk);
      tx_fault = 1'b0;
      wait_state(3'd3, 80, "random_fault_recovery");
    end

    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_state(3'd2, 20, "reach_settle");
    repeat ($urandom_range(0, SP - 3)) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_state(3'd0, "drop_in_settle");
    check_bit(tx_disable, 1'b1, "drop_in_settle_txd");
    enable = 1'b1;
    wait_state(3'd3, 40, "rerun_after_settle_drop");

    tx_fault = 1'b1;
    wait_state(3'd4, 20, "reach_fault");
    repeat ($urandom_range(0, RP - 3)) @(negedge clk);
    enable   = 1'b0;
    tx_fault = 1'b0;
    @(negedge clk);
    check_state(3'd0, "drop_in_fault");
    check_bit(tx_disable, 1'b1, "drop_in_fault_txd");
    enable = 1'b1;
    wait_state(3'd3, 80, "rerun_after_fault_drop");

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) tx_fault = ~tx_fault;
      if ($urandom_range(0, 15) == 0) rx_los   = ~rx_los;
      if ($urandom_range(0, 31) == 0) alarm_b  = ~alarm_b;
      enable = ($urandom_range(0, 63) != 0);
      @(negedge clk);
    end

    enable = 1'b1; alarm_b = 1'b1; rx_los = 1'b0; tx_fault = 1'b1;
    entries = 0; k = 0; prev = state;
    while (entries < 260 && k < 9000) begin
      @(negedge clk);
      k++;
      if (state == 3'd4 && prev != 3'd4) entries++;
      prev = state;
    end
    checks++;
    if (entries == 260) passed++;
    else $display("FAIL fault_loop: got %0d FAULT entries, required 260", entries);
    checks++;
    if (fault_cnt === 8'(FC_MAX)) passed++;
    else $display("FAIL fault_cnt_final: got %0d, required %0d", fault_cnt, FC_MAX);
    tx_fault = 1'b0;
    wait_state(3'd3, 80, "run_before_reset");

    repeat (3) @(negedge clk);
    #2 sys_rst = 1'b1;
    #1 compare("async_reset", actual(), '{st: 3'd0, txd: 1'b1, prst: 1'b1, lnk: 1'b0, fc: 8'd0});
    @(negedge clk);
    sys_rst = 1'b0;
    wait_state(3'd3, 40, "run_after_reset");
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
